// File: rtl/spart_driver.sv
// Processor-side controller for the mini SPART: programs the baud divisor, then echoes received bytes.
// Build option SPART_DRV_FIFO_EN replaces the single holding register with a 4-entry FIFO.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'd1301,
    parameter logic [15:0] DIV_9600  = 16'd650,
    parameter logic [15:0] DIV_19200 = 16'd325,
    parameter logic [15:0] DIV_38400 = 16'd162
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    output logic       busy
);

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    logic [1:0] cfg_meta, cfg_sync;
    logic [1:0] cfg_q, cfg_d;
    logic       iocs_d, iorw_d, busy_d;
    logic [1:0] ioaddr_d;
    logic [7:0] dout_q, dout_d;
    logic       drive_q, drive_d;
    logic [15:0] div_new, div_cur;

    logic       can_rd;
    logic       can_wr;
    logic [7:0] wr_byte;

    function automatic logic [15:0] div_for(input logic [1:0] sel);
        case (sel)
            2'b00:   div_for = DIV_4800;
            2'b01:   div_for = DIV_9600;
            2'b10:   div_for = DIV_19200;
            default: div_for = DIV_38400;
        endcase
    endfunction

    // Switch synchronizer; left unreset so it has settled by the time reset releases.
    always_ff @(posedge clk) begin
        cfg_meta <= br_cfg;
        cfg_sync <= cfg_meta;
    end

    assign databus = drive_q ? dout_q : 8'hzz;

    // State and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CFG_LO;
            ret_q   <= CFG_HI;
            cfg_q   <= 2'b00;
            iocs    <= 1'b0;
            iorw    <= 1'b1;
            ioaddr  <= ADDR_BUF;
            dout_q  <= 8'h00;
            drive_q <= 1'b0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cfg_q   <= cfg_d;
            iocs    <= iocs_d;
            iorw    <= iorw_d;
            ioaddr  <= ioaddr_d;
            dout_q  <= dout_d;
            drive_q <= drive_d;
            busy    <= busy_d;
        end
    end

    // Outputs are computed for the state being entered, so a strobe lines up with its state.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cfg_d    = cfg_q;
        busy_d   = busy;
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = ADDR_BUF;
        dout_d   = 8'h00;
        div_new  = div_for(cfg_sync);
        div_cur  = div_for(cfg_q);

        case (state_q)
            CFG_LO: begin
                // Coming out of reset the low-byte write has not been issued yet.
                if (!iocs) begin
                    cfg_d    = cfg_sync;
                    busy_d   = 1'b1;
                    iocs_d   = 1'b1;
                    iorw_d   = 1'b0;
                    ioaddr_d = ADDR_DIV_LO;
                    dout_d   = div_new[7:0];
                end else begin
                    state_d = GAP;
                    ret_d   = CFG_HI;
                end
            end
            CFG_HI: begin
                state_d = GAP;
                ret_d   = IDLE;
            end
            IDLE: begin
                if (cfg_sync != cfg_q) begin
                    state_d  = CFG_LO;
                    cfg_d    = cfg_sync;
                    busy_d   = 1'b1;
                    iocs_d   = 1'b1;
                    iorw_d   = 1'b0;
                    ioaddr_d = ADDR_DIV_LO;
                    dout_d   = div_new[7:0];
                end else if (can_wr && tbr) begin
                    state_d  = WR;
                    iocs_d   = 1'b1;
                    iorw_d   = 1'b0;
                    ioaddr_d = ADDR_BUF;
                    dout_d   = wr_byte;
                end else if (can_rd && rda) begin
                    state_d  = RD;
                    iocs_d   = 1'b1;
                    iorw_d   = 1'b1;
                    ioaddr_d = ADDR_BUF;
                end
            end
            RD, WR: begin
                state_d = GAP;
                ret_d   = IDLE;
            end
            GAP: begin
                state_d = ret_q;
                if (ret_q == CFG_HI) begin
                    iocs_d   = 1'b1;
                    iorw_d   = 1'b0;
                    ioaddr_d = ADDR_DIV_HI;
                    dout_d   = div_cur[15:8];
                end else if (ret_q == IDLE) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = CFG_LO;
                busy_d  = 1'b1;
            end
        endcase

        drive_d = iocs_d & ~iorw_d;
    end

`ifdef SPART_DRV_FIFO_EN
    localparam int unsigned FIFO_DEPTH = 4;

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;

    assign can_wr  = (count != 3'd0);
    assign can_rd  = (count != 3'(FIFO_DEPTH));
    assign wr_byte = fifo_mem[rd_ptr];

    // Pointers wrap naturally at 2 bits; a read and a write never end in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (state_q == RD) begin
            wr_ptr <= wr_ptr + 2'd1;
            count  <= count + 3'd1;
        end else if (state_q == WR) begin
            rd_ptr <= rd_ptr + 2'd1;
            count  <= count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RD) begin
            fifo_mem[wr_ptr] <= databus;
        end
    end
`else
    logic [7:0] hold_q;
    logic       valid_q;

    assign can_wr  = valid_q;
    assign can_rd  = !valid_q;
    assign wr_byte = hold_q;

    // Single-byte holding register, captured at the edge that ends the read strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (state_q == RD) begin
            hold_q  <= databus;
            valid_q <= 1'b1;
        end else if (state_q == WR) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a simple SPART model plus a scoreboard of expected bus accesses.
module tb_spart_driver;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } acc_t;

`ifdef SPART_DRV_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       busy;
    logic [7:0] rx_byte;

    int   errors = 0;
    int   checks = 0;
    acc_t sb[$];
    acc_t mon_got, mon_exp;
    logic prev_iocs = 1'b0;
    int   n;

    always #5 clk = ~clk;

    spart_driver dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .busy    (busy)
    );

    // SPART side of the bus: returns the rx byte on buffer reads.
    assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic acc_t acc(input logic rw, input logic [1:0] a, input logic [7:0] d);
        return {rw, a, d};
    endfunction

    // Every strobe must match the next scoreboard entry and never follow another strobe.
    always @(negedge clk) begin
        if (iocs) begin
            check("no_back2back", 32'(prev_iocs), 32'd0);
            mon_got = {iorw, ioaddr, databus};
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("strobe", 32'(mon_got), 32'(mon_exp));
            end
        end
        prev_iocs = iocs;
    end

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_iocs(input string tag, input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!iocs && cnt < max);
        check({tag, "_seen"}, 32'(iocs), 32'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (iocs) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
        step(4);
        check("rst_iocs", 32'(iocs), 32'd0);
        check("rst_iorw", 32'(iorw), 32'd1);
        check("rst_ioaddr", 32'(ioaddr), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Initial configuration at 9600 baud: divisor 650 = 0x028A.
        sb.push_back(acc(1'b0, 2'b10, 8'h8A));
        sb.push_back(acc(1'b0, 2'b11, 8'h02));
        rst = 1'b1;
        wait_iocs("cfg_lo", 10, n); check("cfg_lo_lat", 32'(n), 32'd1);
        check("cfg_lo_busy", 32'(busy), 32'd1);
        wait_iocs("cfg_hi", 10, n); check("cfg_hi_lat", 32'(n), 32'd2);
        step(1); check("gap_busy", 32'(busy), 32'd1);
        step(1); check("idle_busy", 32'(busy), 32'd0);
        quiet("idle_quiet", 10);

        // Echo with transmitter ready.
        rx_byte = 8'h41; rda = 1'b1; tbr = 1'b1;
        sb.push_back(acc(1'b1, 2'b00, 8'h41));
        sb.push_back(acc(1'b0, 2'b00, 8'h41));
        wait_iocs("echo_rd", 10, n); check("echo_rd_lat", 32'(n), 32'd1);
        rda = 1'b0;
        wait_iocs("echo_wr", 10, n); check("echo_wr_lat", 32'(n), 32'd3);
        step(2);

        // Transmitter busy: byte is held and no second read happens.
        rx_byte = 8'h55; rda = 1'b1; tbr = 1'b0;
        sb.push_back(acc(1'b1, 2'b00, 8'h55));
        wait_iocs("held_rd", 10, n); check("held_rd_lat", 32'(n), 32'd1);
        step(1);
        rx_byte = 8'h66;
        quiet("held_no_rd", 20);
        sb.push_back(acc(1'b0, 2'b00, 8'h55));
        tbr = 1'b1; rda = 1'b0;
        wait_iocs("held_wr", 10, n); check("held_wr_lat", 32'(n), 32'd1);
        step(2);

        // Baud change during a write strobe: 38400 -> divisor 162 = 0x00A2.
        rx_byte = 8'h77; rda = 1'b1; tbr = 1'b1;
        sb.push_back(acc(1'b1, 2'b00, 8'h77));
        sb.push_back(acc(1'b0, 2'b00, 8'h77));
        wait_iocs("rc_rd", 10, n); check("rc_rd_lat", 32'(n), 32'd1);
        rda = 1'b0;
        wait_iocs("rc_wr", 10, n); check("rc_wr_lat", 32'(n), 32'd3);
        br_cfg = 2'b11;
        sb.push_back(acc(1'b0, 2'b10, 8'hA2));
        sb.push_back(acc(1'b0, 2'b11, 8'h00));
        wait_iocs("rc_lo", 10, n); check("rc_lo_lat", 32'(n), 32'd3);
        check("rc_busy", 32'(busy), 32'd1);
        wait_iocs("rc_hi", 10, n); check("rc_hi_lat", 32'(n), 32'd2);
        step(2); check("rc_busy_done", 32'(busy), 32'd0);
        rx_byte = 8'h3C; rda = 1'b1;
        sb.push_back(acc(1'b1, 2'b00, 8'h3C));
        sb.push_back(acc(1'b0, 2'b00, 8'h3C));
        wait_iocs("resume_rd", 10, n); check("resume_rd_lat", 32'(n), 32'd1);
        rda = 1'b0;
        wait_iocs("resume_wr", 10, n); check("resume_wr_lat", 32'(n), 32'd3);
        step(2);

        // Baud change with a byte buffered: reconfigure first (19200 -> 0x0145), then send it.
        rx_byte = 8'hC3; rda = 1'b1; tbr = 1'b0;
        sb.push_back(acc(1'b1, 2'b00, 8'hC3));
        wait_iocs("keep_rd", 10, n); check("keep_rd_lat", 32'(n), 32'd1);
        rda = 1'b0; br_cfg = 2'b10; tbr = 1'b1;
        sb.push_back(acc(1'b0, 2'b10, 8'h45));
        sb.push_back(acc(1'b0, 2'b11, 8'h01));
        sb.push_back(acc(1'b0, 2'b00, 8'hC3));
        wait_iocs("keep_lo", 10, n); check("keep_lo_lat", 32'(n), 32'd3);
        wait_iocs("keep_hi", 10, n); check("keep_hi_lat", 32'(n), 32'd2);
        wait_iocs("keep_wr", 10, n); check("keep_wr_lat", 32'(n), 32'd3);
        step(2);

        // Reset during a read strobe.
        tbr = 1'b0; rx_byte = 8'h99; rda = 1'b1;
        sb.push_back(acc(1'b1, 2'b00, 8'h99));
        wait_iocs("rm_rd", 10, n); check("rm_rd_lat", 32'(n), 32'd1);
        rst = 1'b0; rda = 1'b0;
        step(1);
        check("rm_iocs", 32'(iocs), 32'd0);
        check("rm_iorw", 32'(iorw), 32'd1);
        check("rm_busy", 32'(busy), 32'd1);
        sb.push_back(acc(1'b0, 2'b10, 8'h45));
        sb.push_back(acc(1'b0, 2'b11, 8'h01));
        step(1);
        rst = 1'b1;
        wait_iocs("rm_lo", 10, n); check("rm_lo_lat", 32'(n), 32'd1);
        wait_iocs("rm_hi", 10, n); check("rm_hi_lat", 32'(n), 32'd2);
        step(2);
        tbr = 1'b1;
        quiet("rm_nothing_held", 8);

        // Fill the buffer with the transmitter stalled, then drain in order.
        tbr = 1'b0; rda = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            rx_byte = 8'(k + 1);
            sb.push_back(acc(1'b1, 2'b00, 8'(k + 1)));
            wait_iocs("fill_rd", 10, n); check("fill_rd_lat", 32'(n), (k == 0) ? 32'd1 : 32'd2);
            step(1);
        end
        rx_byte = 8'(DEPTH + 1);
        quiet("full_no_rd", 12);
        for (int k = 0; k < DEPTH; k++) sb.push_back(acc(1'b0, 2'b00, 8'(k + 1)));
        sb.push_back(acc(1'b1, 2'b00, 8'(DEPTH + 1)));
        sb.push_back(acc(1'b0, 2'b00, 8'(DEPTH + 1)));
        tbr = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            wait_iocs("drain_wr", 10, n); check("drain_wr_lat", 32'(n), (k == 0) ? 32'd1 : 32'd3);
        end
        wait_iocs("last_rd", 10, n); check("last_rd_lat", 32'(n), 32'd3);
        rda = 1'b0;
        wait_iocs("last_wr", 10, n); check("last_wr_lat", 32'(n), 32'd3);
        quiet("final_quiet", 10);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
